// File: rtl/gpio_irq_top.sv
// Wishbone GPIO with input synchronisers, atomic SET/CLR/TGL output updates and
// per-pin edge/level interrupts. Zero-wait-state slave: ack/err one cycle after access.
module gpio_irq_top #(
  parameter int N_PINS      = 32,
  parameter int N_SHARED    = 13,
  parameter int SYNC_STAGES = 2
) (
  input  logic                wb_clk_i,
  input  logic                wb_rst_i,
  input  logic                wb_cyc_i,
  input  logic                wb_stb_i,
  input  logic                wb_we_i,
  input  logic [5:0]          wb_adr_i,
  input  logic [31:0]         wb_dat_i,
  input  logic [3:0]          wb_sel_i,
  output logic [31:0]         wb_dat_o,
  output logic                wb_ack_o,
  output logic                wb_err_o,
  output logic                wb_inta_o,
  input  logic [N_PINS-1:0]   i_gpio,
  output logic [N_PINS-1:0]   o_gpio,
  output logic [N_PINS-1:0]   en_gpio,
  output logic [N_SHARED-1:0] io_sel
);

  localparam logic [3:0] IDX_IN    = 4'd0;
  localparam logic [3:0] IDX_OUT   = 4'd1;
  localparam logic [3:0] IDX_OE    = 4'd2;
  localparam logic [3:0] IDX_IOSEL = 4'd3;
  localparam logic [3:0] IDX_SET   = 4'd4;
  localparam logic [3:0] IDX_CLR   = 4'd5;
  localparam logic [3:0] IDX_TGL   = 4'd6;
  localparam logic [3:0] IDX_IE    = 4'd7;
  localparam logic [3:0] IDX_ITYPE = 4'd8;
  localparam logic [3:0] IDX_IPOL  = 4'd9;
  localparam logic [3:0] IDX_ISTAT = 4'd10;

  logic [N_PINS-1:0]   out_r, oe_r, ie_r, itype_r, ipol_r, istat_r;
  logic [N_SHARED-1:0] iosel_r;
  logic [N_PINS-1:0]   sync_q [SYNC_STAGES];
  logic [N_PINS-1:0]   s, p_q, evt, w1c;
  logic [31:0]         bmask, wdat, rd;
  logic [N_PINS-1:0]   pmask, pdat;
  logic [N_SHARED-1:0] smask, sdat;
  logic [3:0]          idx;
  logic                access, mapped, wr;

  assign idx    = wb_adr_i[5:2];
  assign access = wb_stb_i & wb_cyc_i & ~wb_ack_o & ~wb_err_o;
  assign mapped = (idx <= IDX_ISTAT);
  assign wr     = access & wb_we_i & mapped;

  // Masked-off byte lanes read as zero data, which is also what SET/CLR/TGL/W1C need.
  assign bmask = {{8{wb_sel_i[3]}}, {8{wb_sel_i[2]}}, {8{wb_sel_i[1]}}, {8{wb_sel_i[0]}}};
  assign wdat  = wb_dat_i & bmask;
  assign pmask = bmask[N_PINS-1:0];
  assign pdat  = wdat[N_PINS-1:0];
  assign smask = bmask[N_SHARED-1:0];
  assign sdat  = wdat[N_SHARED-1:0];

  assign s   = sync_q[SYNC_STAGES-1];
  assign evt = (itype_r & ((ipol_r & s & ~p_q) | (~ipol_r & ~s & p_q)))
             | (~itype_r & ~(s ^ ipol_r));
  assign w1c = (wr && idx == IDX_ISTAT) ? pdat : '0;

  always_comb begin
    rd = '0;
    case (idx)
      IDX_IN:    rd[N_PINS-1:0]   = s;
      IDX_OUT:   rd[N_PINS-1:0]   = out_r;
      IDX_OE:    rd[N_PINS-1:0]   = oe_r;
      IDX_IOSEL: rd[N_SHARED-1:0] = iosel_r;
      IDX_IE:    rd[N_PINS-1:0]   = ie_r;
      IDX_ITYPE: rd[N_PINS-1:0]   = itype_r;
      IDX_IPOL:  rd[N_PINS-1:0]   = ipol_r;
      IDX_ISTAT: rd[N_PINS-1:0]   = istat_r;
      default:   rd = '0;
    endcase
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      for (int k = 0; k < SYNC_STAGES; k++) sync_q[k] <= '0;
      p_q <= '0;
    end else begin
      sync_q[0] <= i_gpio;
      for (int k = 1; k < SYNC_STAGES; k++) sync_q[k] <= sync_q[k-1];
      p_q <= s;
    end
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      out_r   <= '0;
      oe_r    <= '0;
      iosel_r <= '0;
      ie_r    <= '0;
      itype_r <= '0;
      ipol_r  <= '0;
    end else if (wr) begin
      case (idx)
        IDX_OUT:   out_r   <= (out_r & ~pmask) | pdat;
        IDX_OE:    oe_r    <= (oe_r & ~pmask) | pdat;
        IDX_IOSEL: iosel_r <= (iosel_r & ~smask) | sdat;
        IDX_SET:   out_r   <= out_r | pdat;
        IDX_CLR:   out_r   <= out_r & ~pdat;
        IDX_TGL:   out_r   <= out_r ^ pdat;
        IDX_IE:    ie_r    <= (ie_r & ~pmask) | pdat;
        IDX_ITYPE: itype_r <= (itype_r & ~pmask) | pdat;
        IDX_IPOL:  ipol_r  <= (ipol_r & ~pmask) | pdat;
        default: ;
      endcase
    end
  end

  // New events win over a same-cycle clear, so a live level source re-asserts at once.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      istat_r   <= '0;
      wb_inta_o <= 1'b0;
    end else begin
      istat_r   <= (istat_r & ~w1c) | (evt & ie_r);
      wb_inta_o <= |(istat_r & ie_r);
    end
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      wb_ack_o <= 1'b0;
      wb_err_o <= 1'b0;
      wb_dat_o <= '0;
    end else begin
      wb_ack_o <= access & mapped;
      wb_err_o <= access & ~mapped;
      if (access) wb_dat_o <= (mapped && !wb_we_i) ? rd : '0;
    end
  end

  assign o_gpio  = out_r;
  assign en_gpio = oe_r;
  assign io_sel  = iosel_r;

endmodule

// File: tb/tb_gpio_irq_top.sv
// Randomised bench for gpio_irq_top: a transaction-level reference model of the
// register map and interrupt rules is compared against the DUT every cycle.
module tb_gpio_irq_top;
  localparam int NP = 16;
  localparam int NS = 13;
  localparam int SS = 2;
  localparam logic [31:0] PM = 32'((64'd1 << NP) - 1);
  localparam logic [31:0] SM = 32'((64'd1 << NS) - 1);

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          cyc = 1'b0, stb = 1'b0, we = 1'b0;
  logic [5:0]    adr = '0;
  logic [31:0]   dat_i = '0;
  logic [3:0]    sel = '0;
  logic [31:0]   dat_o;
  logic          ack, err, inta;
  logic [NP-1:0] i_gpio = '0;
  logic [NP-1:0] o_gpio, en_gpio;
  logic [NS-1:0] io_sel;

  int checks = 0;
  int failures = 0;
  logic run = 1'b0;

  gpio_irq_top #(.N_PINS(NP), .N_SHARED(NS), .SYNC_STAGES(SS)) dut (
    .wb_clk_i(clk), .wb_rst_i(rst), .wb_cyc_i(cyc), .wb_stb_i(stb), .wb_we_i(we),
    .wb_adr_i(adr), .wb_dat_i(dat_i), .wb_sel_i(sel), .wb_dat_o(dat_o),
    .wb_ack_o(ack), .wb_err_o(err), .wb_inta_o(inta), .i_gpio(i_gpio),
    .o_gpio(o_gpio), .en_gpio(en_gpio), .io_sel(io_sel)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: register file plus a history of pad samples.
  logic [31:0] m_out, m_oe, m_iosel, m_ie, m_itype, m_ipol, m_istat;
  logic        m_ack, m_err, m_inta, m_was_rd;
  logic [31:0] m_rd;
  logic [31:0] ph[$];
  logic [31:0] ms, mp, mev, mbm, md, mclr;
  logic        macc, nack, nerr;
  int          mix;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_out = 0; m_oe = 0; m_iosel = 0; m_ie = 0; m_itype = 0; m_ipol = 0; m_istat = 0;
      m_ack = 0; m_err = 0; m_inta = 0; m_was_rd = 0; m_rd = 0;
      ph = {};
      repeat (SS + 1) ph.push_back(32'd0);
    end else begin
      // ph[0] is the previous synchronised sample, ph[1] the current one.
      ms = ph[1];
      mp = ph[0];
      mev = 0;
      for (int i = 0; i < NP; i++) begin
        if (m_itype[i]) mev[i] = m_ipol[i] ? (ms[i] && !mp[i]) : (!ms[i] && mp[i]);
        else            mev[i] = (ms[i] == m_ipol[i]);
      end
      macc = stb && cyc && !m_ack && !m_err;
      nack = 0; nerr = 0; mclr = 0;
      if (macc) begin
        mix = int'(adr[5:2]);
        if (mix > 10) begin
          nerr = 1; m_was_rd = 0;
        end else begin
          nack = 1; m_was_rd = !we;
          case (mix)
            0: m_rd = ms & PM;
            1: m_rd = m_out;
            2: m_rd = m_oe;
            3: m_rd = m_iosel;
            7: m_rd = m_ie;
            8: m_rd = m_itype;
            9: m_rd = m_ipol;
            10: m_rd = m_istat;
            default: m_rd = 0;
          endcase
          if (we) begin
            mbm = 0;
            for (int b = 0; b < 4; b++) if (sel[b]) mbm[8*b +: 8] = 8'hFF;
            md = dat_i & mbm;
            case (mix)
              1: m_out   = ((m_out & ~mbm) | md) & PM;
              2: m_oe    = ((m_oe & ~mbm) | md) & PM;
              3: m_iosel = ((m_iosel & ~mbm) | md) & SM;
              4: m_out   = (m_out | md) & PM;
              5: m_out   = m_out & ~md;
              6: m_out   = (m_out ^ md) & PM;
              7: m_ie    = ((m_ie & ~mbm) | md) & PM;
              8: m_itype = ((m_itype & ~mbm) | md) & PM;
              9: m_ipol  = ((m_ipol & ~mbm) | md) & PM;
              10: mclr   = md & PM;
              default: ;
            endcase
          end
        end
      end
      m_inta  = |(m_istat & m_ie);
      m_istat = ((m_istat & ~mclr) | (mev & m_ie)) & PM;
      m_ack = nack;
      m_err = nerr;
      ph.push_back(32'(i_gpio));
      void'(ph.pop_front());
    end
  end

  always @(negedge clk) begin
    if (run) begin
      chk("ack", 32'(ack), 32'(m_ack));
      chk("err", 32'(err), 32'(m_err));
      chk("inta", 32'(inta), 32'(m_inta));
      chk("o_gpio", 32'(o_gpio), m_out);
      chk("en_gpio", 32'(en_gpio), m_oe);
      chk("io_sel", 32'(io_sel), m_iosel);
      if (m_ack && m_was_rd) chk("rdata", dat_o, m_rd);
      if (m_err) chk("err_data", dat_o, 32'd0);
    end
  end

  task automatic bus(input logic w, input int ix, input logic [31:0] d,
                     input logic [3:0] s, output logic [31:0] rdv);
    logic [3:0] ixb;
    ixb = ix[3:0];
    @(negedge clk);
    cyc = 1; stb = 1; we = w; adr = {ixb, 2'b00}; dat_i = d; sel = s;
    @(negedge clk);
    rdv = dat_o;
    chk("bus_ack", 32'(ack), 32'(ix <= 10));
    chk("bus_err", 32'(err), 32'(ix > 10));
    cyc = 0; stb = 0; we = 0;
  endtask

  task automatic wr(input int ix, input logic [31:0] d);
    logic [31:0] dummy;
    bus(1'b1, ix, d, 4'hF, dummy);
  endtask

  task automatic rdr(input int ix, output logic [31:0] v);
    bus(1'b0, ix, 32'd0, 4'hF, v);
  endtask

  task automatic cyc_wait(input int n);
    repeat (n) @(negedge clk);
  endtask

  logic [31:0] v, pv;

  initial begin
    pv = $urandom & PM;
    i_gpio = pv[NP-1:0];
    #1 rst = 1;
    run = 1;
    cyc_wait(3);
    rst = 0;
    cyc_wait(SS + 2);
    for (int i = 0; i <= 10; i++) begin
      rdr(i, v);
      chk($sformatf("reset_rd%0d", i), v, (i == 0) ? pv : 32'd0);
    end
    rdr(12, v);
    chk("unmapped_dat", v, 32'd0);
    chk("inta_after_reset", 32'(inta), 32'd0);

    // Atomic output ops and byte lanes.
    i_gpio = '0;
    wr(1, 32'h0000_00F0); wr(4, 32'h0F); wr(5, 32'h30); wr(6, 32'h81);
    chk("o_gpio_atomic", 32'(o_gpio), 32'h4E);
    rdr(1, v);
    chk("out_readback", v, 32'h4E);
    wr(1, 32'd0);
    bus(1'b1, 1, 32'hFFFF_FFFF, 4'b0010, v);
    chk("out_bytelane", 32'(o_gpio), 32'h0000_FF00);
    wr(2, 32'hFFFF_FFFF);
    chk("en_gpio_trunc", 32'(en_gpio), PM);
    rdr(2, v);
    chk("oe_readback", v, PM);
    wr(3, 32'hFFFF_FFFF);
    chk("io_sel_trunc", 32'(io_sel), 32'h1FFF);

    // Rising-edge interrupt on bit 3.
    wr(8, 32'h8); wr(9, 32'h8); wr(7, 32'h8);
    i_gpio[3] = 1'b1;
    cyc_wait(SS + 1);
    chk("edge_inta_early", 32'(inta), 32'd0);
    cyc_wait(1);
    chk("edge_inta", 32'(inta), 32'd1);
    rdr(10, v);
    chk("edge_istat", v, 32'h8);
    wr(10, 32'h8);
    rdr(10, v);
    chk("edge_w1c", v, 32'd0);
    chk("edge_inta_clr", 32'(inta), 32'd0);
    i_gpio[3] = 1'b0;
    cyc_wait(SS + 3);
    rdr(10, v);
    chk("edge_fall_ignored", v, 32'd0);

    // Level-high interrupt on bit 0.
    wr(9, 32'h9); wr(7, 32'h1);
    i_gpio[0] = 1'b1;
    cyc_wait(SS + 2);
    chk("level_inta", 32'(inta), 32'd1);
    wr(10, 32'h1);
    chk("level_inta_held", 32'(inta), 32'd1);
    rdr(10, v);
    chk("level_w1c_resets", v, 32'h1);
    i_gpio[0] = 1'b0;
    cyc_wait(SS + 2);
    wr(10, 32'h1);
    rdr(10, v);
    chk("level_cleared", v, 32'd0);
    chk("level_inta_clr", 32'(inta), 32'd0);

    // Randomised traffic and pad activity.
    for (int n = 0; n < 400; n++) begin
      if ($urandom_range(3) == 0) i_gpio = NP'($urandom);
      if ($urandom_range(7) == 0) cyc_wait($urandom_range(1, 4));
      bus(1'($urandom_range(1)), int'($urandom_range(15)), $urandom,
          4'($urandom_range(15)), v);
    end

    // Reset in the middle of a read with an interrupt pending.
    wr(8, 32'h0); wr(9, 32'h1); wr(7, 32'h1); wr(1, 32'hA5);
    i_gpio = '0;
    i_gpio[0] = 1'b1;
    cyc_wait(SS + 2);
    chk("pre_rst_inta", 32'(inta), 32'd1);
    @(negedge clk);
    cyc = 1; stb = 1; we = 0; adr = {4'd10, 2'b00}; sel = 4'hF;
    #2 rst = 1;
    #1;
    chk("rst_ack", 32'(ack), 32'd0);
    chk("rst_inta", 32'(inta), 32'd0);
    chk("rst_o_gpio", 32'(o_gpio), 32'd0);
    @(negedge clk);
    chk("rst_ack_hold", 32'(ack), 32'd0);
    rst = 0; cyc = 0; stb = 0;
    @(negedge clk);
    chk("rst_no_late_ack", 32'(ack), 32'd0);
    rdr(10, v);
    chk("rst_istat", v, 32'd0);

    run = 0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/gpio_irq_top.md
Name: gpio_irq_top

Overview:
Parametrised Wishbone GPIO controller that follows the current simple GPIO. It adds input synchronisers, atomic SET/CLR/TGL output updates, and per-pin interrupts. Interrupts are edge or level, with selectable polarity, and status is write-1-to-clear. The block sits on the peripheral Wishbone bus: pins go to the pad ring, io_sel goes to the shared-pin mux, and wb_inta_o goes to the interrupt controller.

Parameters:
N_PINS, 32, number of GPIO pins (1..32); register bits at or above N_PINS read 0 and ignore writes
N_SHARED, 13, width of the io_sel shared-pin select register (1..32)
SYNC_STAGES, 2, flop stages on i_gpio before the IN register and interrupt logic (≥2)

Ports:
wb_clk_i  in  1  clock
wb_rst_i  in  1  reset, asynchronous, active-high
wb_cyc_i  in  1  bus cycle valid
wb_stb_i  in  1  strobe
wb_we_i  in  1  write enable
wb_adr_i  in  6  byte address; word index is wb_adr_i[5:2], bits [1:0] are ignored
wb_dat_i  in  32  write data
wb_sel_i  in  4  byte lane enables
wb_dat_o  out  32  read data, registered, valid with ack
wb_ack_o  out  1  normal termination, registered
wb_err_o  out  1  error termination for an unmapped word index
wb_inta_o  out  1  interrupt request, active-high
i_gpio  in  N_PINS  pad inputs, asynchronous
o_gpio  out  N_PINS  pad output values (= OUT)
en_gpio  out  N_PINS  pad output enables (= OE)
io_sel  out  N_SHARED  shared-pin function select

Behaviour:
- Register map (word index):
  - 0 IN: RO, synchronised pins.
  - 1 OUT: RW.
  - 2 OE: RW.
  - 3 IOSEL: RW.
  - 4 OUT_SET, 5 OUT_CLR, 6 OUT_TGL: WO, read as 0.
  - 7 IE: RW, interrupt enable.
  - 8 ITYPE: RW; 1 = edge, 0 = level.
  - 9 IPOL: RW; 1 = rising/high, 0 = falling/low.
  - 10 ISTAT: RW1C.
  - Indices 11..15 are unmapped.
- Reset: all registers, sync chain, previous-sample flops, wb_ack_o, wb_err_o, wb_dat_o, wb_inta_o and all outputs are 0.
- Bus handshake:
  - An access is stb & cyc & ~ack & ~err.
  - The cycle after an access, exactly one of ack/err pulses high for one cycle. Zero wait states, so back-to-back accesses complete every 2 cycles.
  - Register writes and read data are captured on the access cycle.
  - Unmapped index: err=1, no register changes, wb_dat_o=0.
  - If stb/cyc drop before completion, the pending ack/err still fires once.
- Byte lanes: every write honours wb_sel_i per byte. For SET/CLR/TGL, masked-off bytes are treated as zero data.
- Atomic output ops: OUT_SET gives OUT |= d, OUT_CLR gives OUT &= ~d, OUT_TGL gives OUT ^= d. The result is visible on o_gpio the cycle after the access.
- Synchroniser: i_gpio passes through SYNC_STAGES flops to give s. IN = s, so a pad change appears in IN after SYNC_STAGES cycles.
- Interrupt detection: p is s delayed by one cycle. Per bit i, event_i is:
  - edge rising (ITYPE=1, IPOL=1): s&~p
  - edge falling (ITYPE=1, IPOL=0): ~s&p
  - level (ITYPE=0): s==IPOL
- Status update: ISTAT_i is set on event_i & IE_i. A W1C write clears the written bits.
  - If set and clear happen in the same cycle, set wins.
  - An active level source re-sets ISTAT the cycle after it is cleared.
- wb_inta_o is registered: the OR over (ISTAT & IE), one cycle after ISTAT changes.
- Clearing IE masks wb_inta_o but does not clear ISTAT.
- After reset with a pin held high, a rising edge is seen once the chain fills. It is ignored because IE=0.
- Reset asserted mid-transfer clears everything immediately. No ack is issued for the interrupted access.

Test Plan:
- Reset, then read indices 0..10 → all read 0 except IN = synchronised pins; ack exactly 1 cycle after each strobe; read index 12 → err=1, ack=0, dat=0.
- Write OUT=0x0000_00F0 → SET 0x0F → CLR 0x30 → TGL 0x81 → o_gpio reads back 0x4E; write OUT=0xFFFF_FFFF with sel=4'b0010 from 0 → OUT=0x0000_FF00.
- N_PINS=8: write OE=0xFFFF_FFFF → en_gpio=0xFF, readback 0x0000_00FF; IOSEL write 0xFFFF_FFFF → io_sel=0x1FFF (N_SHARED=13).
- Bit 3: ITYPE=1, IPOL=1, IE=0x8; pulse i_gpio[3] 0→1 → ISTAT=0x8 after SYNC_STAGES+1 cycles, wb_inta_o=1 one cycle later; W1C 0x8 → ISTAT=0, inta=0; falling edge → no set.
- Bit 0: level high, IE=1, pin held 1 → W1C 0x1 does not stick (ISTAT=1 next cycle, inta stays 1); drop pin, W1C → ISTAT=0, inta=0.
- Assert wb_rst_i mid-read and with ISTAT pending → ack never fires, ISTAT=0, inta=0, o_gpio=0 asynchronously.
